// File: rtl/act_pkg.sv
// act_pkg: shared mode/select encodings and the
// output saturation helper for the ACT activation path.
`ifndef MAX_DAT_DW
`define MAX_DAT_DW 16
`endif

package act_pkg;

   localparam int ACT_DW = `MAX_DAT_DW;

   typedef enum logic [1:0] {
      ACT_BYPASS = 2'd0,
      ACT_RELU   = 2'd1,
      ACT_PWL    = 2'd2
   } act_mode_e;

   localparam logic [1:0] SEL_BP = 2'd0;
   localparam logic [1:0] SEL_K  = 2'd1;
   localparam logic [1:0] SEL_B  = 2'd2;

   // Clamp v to the signed range of a dw-bit word (dw <= 31).
   function automatic logic signed [63:0] sat_dw(
      input logic signed [63:0] v,
      input int                 dw
   );
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (dw - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/act_pwl_lane.sv
// act_pwl_lane: one lane of the activation pipeline:
// segment select, multiply, shift/add/saturate.
module act_pwl_lane
   import act_pkg::*;
#(
   parameter int DW         = ACT_DW,
   parameter int NSEG       = 16,
   parameter int SLOPE_FRAC = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [DW-1:0]            x_in,
   input  logic [1:0]               mode_s2,
   input  logic [(NSEG-1)*DW-1:0]   bp_flat,
   input  logic [NSEG*DW-1:0]       k_flat,
   input  logic [NSEG*DW-1:0]       b_flat,
   output logic [DW-1:0]            y_out
);

   localparam int SW = $clog2(NSEG);
   localparam int PW = 2 * DW;

   logic [SW-1:0]        seg;
   logic signed [DW-1:0] x1, k1, b1;
   logic signed [DW-1:0] x2, b2;
   logic signed [PW-1:0] p2, sh;
   logic signed [PW:0]   sum;
   logic [DW-1:0]        y_nxt, y3;

   // Segment index: number of breakpoints at or below x.
   always_comb begin
      seg = '0;
      for (int j = 0; j < NSEG - 1; j++)
         if ($signed(bp_flat[j*DW +: DW]) <= $signed(x_in))
            seg = seg + SW'(1);
   end

   // S1: capture x and its slope/bias so later table writes cannot touch it.
   always_ff @(posedge clk) begin
      if (rst) begin
         x1 <= '0;
         k1 <= '0;
         b1 <= '0;
      end else if (en) begin
         x1 <= x_in;
         k1 <= k_flat[seg*DW +: DW];
         b1 <= b_flat[seg*DW +: DW];
      end
   end

   // S2: full-precision signed product.
   always_ff @(posedge clk) begin
      if (rst) begin
         x2 <= '0;
         b2 <= '0;
         p2 <= '0;
      end else if (en) begin
         x2 <= x1;
         b2 <= b1;
         p2 <= PW'(x1) * PW'(k1);
      end
   end

   // S3 result: floor shift, add bias one bit wider, then clamp.
   always_comb begin
      sh    = p2 >>> SLOPE_FRAC;
      sum   = (PW+1)'(sh) + (PW+1)'(b2);
      y_nxt = x2;
      unique case (1'b1)
         mode_s2 == ACT_PWL:  y_nxt = DW'(sat_dw(64'(sum), DW));
         mode_s2 == ACT_RELU: y_nxt = x2[DW-1] ? '0 : x2;
         default: ;
      endcase
   end

   // S3: output register, held during stalls.
   always_ff @(posedge clk) begin
      if (rst)
         y3 <= '0;
      else if (en)
         y3 <= y_nxt;
   end

   assign y_out = y3;

endmodule

// File: rtl/act_pwl_stream.sv
// act_pwl_stream: multi-lane bypass/ReLU/PWL activation
// with a writable table and a stallable 3-stage pipeline.
module act_pwl_stream
   import act_pkg::*;
#(
   parameter int LANES      = 32,
   parameter int DW         = ACT_DW,
   parameter int NSEG       = 16,
   parameter int SLOPE_FRAC = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              cfg_mode,
   input  logic                    cfg_we,
   input  logic [1:0]              cfg_sel,
   input  logic [$clog2(NSEG)-1:0] cfg_addr,
   input  logic [DW-1:0]           cfg_wdata,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*DW-1:0]     in_data,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*DW-1:0]     out_data,
   output logic                    out_last,
   output logic                    busy
);

   logic [(NSEG-1)*DW-1:0] bp_tab;
   logic [NSEG*DW-1:0]     k_tab;
   logic [NSEG*DW-1:0]     b_tab;

   logic       en;
   logic       v1, v2, v3;
   logic       l1, l2, l3;
   logic [1:0] m1, m2;

   assign en       = ~v3 | out_ready;
   assign in_ready = en;

   // Table writes: decode select/index, ignore out-of-range entries.
   always_ff @(posedge clk) begin
      if (rst) begin
         bp_tab <= '0;
         k_tab  <= '0;
         b_tab  <= '0;
      end else if (cfg_we) begin
         unique case (1'b1)
            cfg_sel == SEL_BP && 32'(cfg_addr) < NSEG - 1:
               bp_tab[cfg_addr*DW +: DW] <= cfg_wdata;
            cfg_sel == SEL_K && 32'(cfg_addr) < NSEG:
               k_tab[cfg_addr*DW +: DW] <= cfg_wdata;
            cfg_sel == SEL_B && 32'(cfg_addr) < NSEG:
               b_tab[cfg_addr*DW +: DW] <= cfg_wdata;
            default: ;
         endcase
      end
   end

   // Valid/last/mode travel alongside the lane data.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
         l1 <= 1'b0;
         l2 <= 1'b0;
         l3 <= 1'b0;
         m1 <= '0;
         m2 <= '0;
      end else if (en) begin
         v1 <= in_valid;
         l1 <= in_valid & in_last;
         m1 <= cfg_mode;
         v2 <= v1;
         l2 <= l1;
         m2 <= m1;
         v3 <= v2;
         l3 <= l2;
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      act_pwl_lane #(
         .DW         (DW),
         .NSEG       (NSEG),
         .SLOPE_FRAC (SLOPE_FRAC)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .en      (en),
         .x_in    (in_data[i*DW +: DW]),
         .mode_s2 (m2),
         .bp_flat (bp_tab),
         .k_flat  (k_tab),
         .b_flat  (b_tab),
         .y_out   (out_data[i*DW +: DW])
      );
   end

   assign out_valid = v3;
   assign out_last  = l3;
   assign busy      = v1 | v2 | v3;

endmodule

// File: tb/tb_act_pwl_stream.sv
// tb_act_pwl_stream: scoreboard bench for act_pwl_stream
// (LANES=4, DW=16, NSEG=4, SLOPE_FRAC=8).
module tb_act_pwl_stream;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  cfg_mode;
   logic        cfg_we;
   logic [1:0]  cfg_sel;
   logic [1:0]  cfg_addr;
   logic [15:0] cfg_wdata;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        out_last;
   logic        busy;

   act_pwl_stream #(
      .LANES(4), .DW(16), .NSEG(4), .SLOPE_FRAC(8)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_mode(cfg_mode), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
      .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .busy(busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input bit ok, input string nm,
                      input longint act, input longint exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Reference table, updated when the bench sees a write commit.
   longint mbp[3];
   longint mk[4];
   longint mb[4];

   function automatic logic [63:0] model(input logic [63:0] d,
                                         input logic [1:0] m);
      logic [63:0] r;
      longint x, y, p;
      int seg;
      r = '0;
      for (int l = 0; l < 4; l++) begin
         x = longint'($signed(d[l*16 +: 16]));
         if (m == 2'd2) begin
            seg = 0;
            for (int j = 0; j < 3; j++)
               if (mbp[j] <= x) seg++;
            p = x * mk[seg];
            y = (p >>> 8) + mb[seg];
            if (y > 32767)  y = 32767;
            if (y < -32768) y = -32768;
         end else if (m == 2'd1) begin
            y = (x < 0) ? 0 : x;
         end else begin
            y = x;
         end
         r[l*16 +: 16] = 16'(y);
      end
      return r;
   endfunction

   function automatic logic [63:0] pack4(input int a, input int b,
                                         input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   typedef struct {
      logic [63:0] exp;
      logic        last;
      bit          has_lit;
      logic [63:0] lit;
      int          cyc;
   } ent_t;

   ent_t        q[$];
   bit          lit_has = 0;
   logic [63:0] lit_val = '0;
   int          cyc = 0;
   int          post_rst = 0;
   bit          prev_stall = 0;
   logic [63:0] prev_data;
   logic        prev_last;

   // Single compare process: handshake rules, scoreboard, table tracking.
   always @(negedge clk) begin
      ent_t e;
      cyc++;
      if (rst) begin
         q.delete();
         foreach (mbp[j]) mbp[j] = 0;
         foreach (mk[j]) mk[j] = 0;
         foreach (mb[j]) mb[j] = 0;
         post_rst   = 3;
         prev_stall = 0;
      end else begin
         if (post_rst > 0) begin
            chk(!out_valid, "post_rst_quiet", out_valid, 0);
            post_rst--;
         end
         chk(in_ready == (!out_valid || out_ready), "in_ready",
             in_ready, !out_valid || out_ready);
         chk(busy == (q.size() != 0), "busy", busy, q.size() != 0);
         if (prev_stall)
            chk(out_valid && out_data == prev_data &&
                out_last == prev_last, "stall_hold", out_data, prev_data);
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk(0, "spurious_out", out_data, 0);
            end else begin
               e = q.pop_front();
               chk(out_data == e.exp, "data", out_data, e.exp);
               chk(out_last == e.last, "last", out_last, e.last);
               if (e.has_lit) begin
                  chk(e.exp == e.lit, "model_pin", e.exp, e.lit);
                  chk(cyc - e.cyc == 3, "latency", cyc - e.cyc, 3);
               end
            end
         end
         if (in_valid && in_ready) begin
            e.exp     = model(in_data, cfg_mode);
            e.last    = in_last;
            e.has_lit = lit_has;
            e.lit     = lit_val;
            e.cyc     = cyc;
            q.push_back(e);
         end
         if (cfg_we) begin
            if (cfg_sel == 2'd0 && cfg_addr < 2'd3)
               mbp[cfg_addr] = longint'($signed(cfg_wdata));
            else if (cfg_sel == 2'd1)
               mk[cfg_addr] = longint'($signed(cfg_wdata));
            else if (cfg_sel == 2'd2)
               mb[cfg_addr] = longint'($signed(cfg_wdata));
         end
      end
   end

   bit rnd_bp = 0;
   always @(posedge clk)
      if (rnd_bp) #2 out_ready = ($urandom % 4) != 0;

   task automatic send(input logic [63:0] d, input logic [1:0] m,
                       input logic last, input bit hl,
                       input logic [63:0] lv);
      int n;
      bit acc;
      in_data  = d;
      cfg_mode = m;
      in_last  = last;
      in_valid = 1'b1;
      lit_has  = hl;
      lit_val  = lv;
      n = 0;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 1000);
      if (!acc) chk(0, "accept_timeout", 0, 1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      lit_has  = 0;
   endtask

   task automatic wr(input logic [1:0] sel, input logic [1:0] a,
                     input int v);
      cfg_we    = 1'b1;
      cfg_sel   = sel;
      cfg_addr  = a;
      cfg_wdata = 16'(v);
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((busy || q.size() != 0) && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(!busy && q.size() == 0, "drain", busy, 0);
   endtask

   function automatic logic [15:0] rnd_lane();
      case ($urandom % 6)
         0: return 16'h8000;
         1: return 16'h7fff;
         2: return 16'h0000;
         3: return 16'hffff;
         default: return 16'($urandom);
      endcase
   endfunction

   function automatic logic [63:0] rnd_beat();
      return {rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()};
   endfunction

   initial begin
      rst       = 1'b1;
      cfg_mode  = 2'd0;
      cfg_we    = 1'b0;
      cfg_sel   = 2'd0;
      cfg_addr  = 2'd0;
      cfg_wdata = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk(in_ready == 1'b1, "rst_in_ready", in_ready, 1);
      chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
      chk(out_data == 64'd0, "rst_out_data", out_data, 0);
      chk(out_last == 1'b0, "rst_out_last", out_last, 0);
      @(posedge clk);
      #1;

      // Zero table after reset: PWL yields zero.
      send(pack4(100, -5, 0, 7), 2'd2, 1'b0, 1, 64'd0);
      // ReLU, bypass, reserved.
      send(pack4(-32768, -1, 5, 32767), 2'd1, 1'b0, 1,
           pack4(0, 0, 5, 32767));
      send(pack4(1234, -4321, -32768, 32767), 2'd0, 1'b1, 1,
           pack4(1234, -4321, -32768, 32767));
      send(pack4(-7, 9, -32768, 1), 2'd3, 1'b0, 1,
           pack4(-7, 9, -32768, 1));
      drain();

      // PWL table: bp={-256,0,256} k={0,128,256,0} b={-64,0,0,256}.
      wr(2'd0, 2'd0, -256);
      wr(2'd0, 2'd1, 0);
      wr(2'd0, 2'd2, 256);
      wr(2'd0, 2'd3, 999);
      wr(2'd1, 2'd0, 0);
      wr(2'd1, 2'd1, 128);
      wr(2'd1, 2'd2, 256);
      wr(2'd1, 2'd3, 0);
      wr(2'd2, 2'd0, -64);
      wr(2'd2, 2'd1, 0);
      wr(2'd2, 2'd2, 0);
      wr(2'd2, 2'd3, 256);
      send(pack4(-1000, -100, 100, 256), 2'd2, 1'b0, 1,
           pack4(-64, -50, 100, 256));
      send(pack4(-256, -257, 255, 0), 2'd2, 1'b0, 1,
           pack4(-128, -64, 255, 0));
      drain();

      // Write collision: same-cycle beat uses the old k[2].
      cfg_we    = 1'b1;
      cfg_sel   = 2'd1;
      cfg_addr  = 2'd2;
      cfg_wdata = 16'd512;
      send(pack4(100, 100, 100, 100), 2'd2, 1'b0, 1,
           pack4(100, 100, 100, 100));
      cfg_we = 1'b0;
      send(pack4(100, 100, 100, 100), 2'd2, 1'b0, 1,
           pack4(200, 200, 200, 200));
      drain();

      // Saturation, positive slope/bias.
      for (int i = 0; i < 4; i++) begin
         wr(2'd1, 2'(i), 32767);
         wr(2'd2, 2'(i), 32767);
      end
      send(pack4(32767, -32768, 0, 1), 2'd2, 1'b0, 1,
           pack4(32767, -32768, 32767, 32767));
      drain();
      // Most negative x times most negative slope.
      for (int i = 0; i < 4; i++) begin
         wr(2'd1, 2'(i), -32768);
         wr(2'd2, 2'(i), 0);
      end
      send(pack4(-32768, 1, 256, -1), 2'd2, 1'b0, 1,
           pack4(32767, -128, -32768, 128));
      drain();

      // Backpressure: 8 back-to-back beats, sink stalls mid-burst.
      fork
         for (int i = 0; i < 8; i++)
            send(rnd_beat(), 2'd2, i == 7, 0, 64'd0);
         begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      // Mid-stream reset with three beats parked in the pipe.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         send(rnd_beat(), 2'd2, 1'b0, 0, 64'd0);
      rst       = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      send(pack4(100, -5, 0, 7), 2'd2, 1'b0, 1, 64'd0);
      drain();

      // Randomized traffic, table writes and sink stalls.
      rnd_bp = 1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom % 5 == 0) begin
            cfg_we    = 1'b1;
            cfg_sel   = 2'($urandom);
            cfg_addr  = 2'($urandom);
            cfg_wdata = rnd_lane();
         end
         if ($urandom % 4 == 0) begin
            @(posedge clk);
            #1;
         end else begin
            send(rnd_beat(), 2'($urandom), ($urandom % 8) == 0,
                 0, 64'd0);
         end
         cfg_we = 1'b0;
      end
      rnd_bp = 0;
      @(posedge clk);
      #3 out_ready = 1'b1;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
